// File: rtl/ext_pkg.sv
// rtl/ext_pkg.sv - shared extension-mode encodings for ext_pipe
package ext_pkg;

   // Extension modes carried on the EOp field
   typedef enum logic [1:0] {
      EOP_SIGN = 2'b00,
      EOP_ZERO = 2'b01,
      EOP_LUI  = 2'b10,
      EOP_BR   = 2'b11
   } eop_e;

endpackage

// File: rtl/ext_pipe_if.sv
// rtl/ext_pipe_if.sv - request/result handshake bundle for ext_pipe
interface ext_pipe_if #(
   parameter int IMM_W  = 16,
   parameter int DATA_W = 32,
   parameter int DEPTH  = 2
);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic              in_valid;
   logic              in_ready;
   logic [IMM_W-1:0]  imm;
   logic [1:0]        EOp;
   logic              flush;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] ext;
   logic [CNT_W-1:0]  count;

   modport master (
      output in_valid, imm, EOp, flush, out_ready,
      input  in_ready, out_valid, ext, count
   );

   modport slave (
      input  in_valid, imm, EOp, flush, out_ready,
      output in_ready, out_valid, ext, count
   );

endinterface

// File: rtl/ext_core.sv
// rtl/ext_core.sv - combinational immediate extender; EXT_PIPE_BRANCH_EN selects branch-offset mode
module ext_core
   import ext_pkg::*;
#(
   parameter int IMM_W  = 16,
   parameter int DATA_W = 32
) (
   input  logic [IMM_W-1:0]  imm,
   input  logic [1:0]        EOp,
   output logic [DATA_W-1:0] ext
);

   logic [DATA_W-1:0] sext;

   // Select the extension; mode 11 falls back to sign-extend unless branch offsets are built in
   always_comb begin
      sext = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
      ext  = sext;
      case (eop_e'(EOp))
         EOP_SIGN: ext = sext;
         EOP_ZERO: ext = {{(DATA_W-IMM_W){1'b0}}, imm};
         EOP_LUI:  ext = {imm, {(DATA_W-IMM_W){1'b0}}};
         EOP_BR: begin
`ifdef EXT_PIPE_BRANCH_EN
            ext = sext << 2;
`else
            ext = sext;
`endif
         end
         default:  ext = sext;
      endcase
   end

endmodule

// File: rtl/ext_pipe.sv
// rtl/ext_pipe.sv - immediate extender feeding a DEPTH-entry result FIFO; EXT_PIPE_BRANCH_EN via ext_core
module ext_pipe #(
   parameter int IMM_W  = 16,
   parameter int DATA_W = 32,
   parameter int DEPTH  = 2
) (
   input logic       clk,
   input logic       reset,
   ext_pipe_if.slave bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [DATA_W-1:0] core_ext;
   logic              push;
   logic              pop;

   ext_core #(
      .IMM_W  (IMM_W),
      .DATA_W (DATA_W)
   ) u_core (
      .imm (bus.imm),
      .EOp (bus.EOp),
      .ext (core_ext)
   );

   // Ready depends only on registered occupancy so no combinational path from out_ready
   assign bus.in_ready  = (count_q < DEPTH_C);
   assign bus.out_valid = (count_q != '0);
   assign bus.ext       = bus.out_valid ? mem_q[rd_ptr_q] : '0;
   assign bus.count     = count_q;

   assign push = bus.in_valid && bus.in_ready;
   assign pop  = bus.out_valid && bus.out_ready;

   // Next pointers/occupancy; flush wins over any same-cycle push or pop
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (bus.flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   // Control state register; reset overrides everything
   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Result storage; left unreset because empty entries are never presented
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= core_ext;
   end

endmodule

// File: tb/tb_ext_pipe.sv
// tb/tb_ext_pipe.sv - self-checking bench for ext_pipe: vector table, corner sequences, random vs queue model
module tb_ext_pipe;
   localparam int IMM_W  = 16;
   localparam int DATA_W = 32;
   localparam int DEPTH  = 2;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   ext_pipe_if #(.IMM_W(IMM_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

   ext_pipe #(.IMM_W(IMM_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      string       name;
      logic [15:0] imm;
      logic [1:0]  eop;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs [7];
   logic [31:0] exp_q [$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.in_valid  = 1'b0;
      bus.flush     = 1'b0;
      bus.out_ready = 1'b1;
      bus.imm       = '0;
      bus.EOp       = 2'b00;
   endtask

   task automatic fill2();
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.EOp       = 2'b01;
      bus.imm       = 16'h00A1;
      step();
      bus.imm       = 16'h00A2;
      step();
      bus.in_valid  = 1'b0;
      chk("fill2_count", 64'(bus.count), 64'd2);
   endtask

   // Reference extension from arithmetic on the immediate's value
   function automatic logic [31:0] model_ext(input logic [15:0] imm, input logic [1:0] eop);
      longint s;
      s = (imm >= 16'h8000) ? longint'(imm) - 65536 : longint'(imm);
      case (eop)
         2'd0: return 32'(s);
         2'd1: return 32'(longint'(imm));
         2'd2: return 32'(longint'(imm) * 65536);
         default: begin
`ifdef EXT_PIPE_BRANCH_EN
            return 32'(s * 4);
`else
            return 32'(s);
`endif
         end
      endcase
   endfunction

   initial begin
      vecs[0] = '{"sign_ffff", 16'hFFFF, 2'b00, 32'hFFFFFFFF};
      vecs[1] = '{"zero_ffff", 16'hFFFF, 2'b01, 32'h0000FFFF};
      vecs[2] = '{"lui_7fff",  16'h7FFF, 2'b10, 32'h7FFF0000};
`ifdef EXT_PIPE_BRANCH_EN
      vecs[3] = '{"br_7fff",   16'h7FFF, 2'b11, 32'h0001FFFC};
      vecs[4] = '{"br_ffff",   16'hFFFF, 2'b11, 32'hFFFFFFFC};
`else
      vecs[3] = '{"br_7fff",   16'h7FFF, 2'b11, 32'h00007FFF};
      vecs[4] = '{"br_ffff",   16'hFFFF, 2'b11, 32'hFFFFFFFF};
`endif
      vecs[5] = '{"sign_8000", 16'h8000, 2'b00, 32'hFFFF8000};
      vecs[6] = '{"lui_0001",  16'h0001, 2'b10, 32'h00010000};

      idle();
      reset = 1'b0;
      step();
      step();
      chk("rst_count",     64'(bus.count),     64'd0);
      chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_ext",       64'(bus.ext),       64'd0);
      chk("rst_in_ready",  64'(bus.in_ready),  64'd1);
      reset = 1'b1;
      step();

      // Mode table: each result must appear one cycle after accept
      foreach (vecs[i]) begin
         bus.in_valid = 1'b1;
         bus.imm      = vecs[i].imm;
         bus.EOp      = vecs[i].eop;
         step();
         bus.in_valid = 1'b0;
         chk({vecs[i].name, "_valid"}, 64'(bus.out_valid), 64'd1);
         chk({vecs[i].name, "_ext"},   64'(bus.ext),       64'(vecs[i].exp));
         step();
         chk({vecs[i].name, "_drain"}, 64'(bus.count),     64'd0);
      end

      // Backpressure: third request refused while full, head held stable
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.EOp       = 2'b01;
      bus.imm       = 16'h0001;
      step();
      chk("bp_count1", 64'(bus.count), 64'd1);
      bus.imm = 16'h0002;
      step();
      chk("bp_count2",   64'(bus.count),    64'd2);
      chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
      bus.imm = 16'h0003;
      step();
      chk("bp_full_count", 64'(bus.count), 64'd2);
      chk("bp_hold_ext",   64'(bus.ext),   64'h1);
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      step();
      chk("bp_pop1_count", 64'(bus.count), 64'd1);
      chk("bp_pop1_ext",   64'(bus.ext),   64'h2);
      step();
      chk("bp_pop2_count", 64'(bus.count),     64'd0);
      chk("bp_pop2_valid", 64'(bus.out_valid), 64'd0);
      chk("bp_pop2_ext",   64'(bus.ext),       64'd0);

      // Simultaneous push/pop at count 1 across pointer wrap
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.EOp       = 2'b01;
      bus.imm       = 16'h0100;
      step();
      bus.out_ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         bus.imm = 16'(16'h0100 + i);
         step();
         chk($sformatf("pp_count_%0d", i), 64'(bus.count), 64'd1);
         chk($sformatf("pp_ext_%0d", i),   64'(bus.ext),   64'(32'h100 + i));
      end
      bus.in_valid = 1'b0;
      step();
      chk("pp_drain", 64'(bus.count), 64'd0);

      // Flush while full with a request pending
      fill2();
      bus.flush    = 1'b1;
      bus.in_valid = 1'b1;
      bus.imm      = 16'h0055;
      step();
      bus.flush    = 1'b0;
      bus.in_valid = 1'b0;
      chk("fl_count", 64'(bus.count),     64'd0);
      chk("fl_valid", 64'(bus.out_valid), 64'd0);
      step();
      chk("fl_dropped", 64'(bus.count), 64'd0);

      // Flush at count 1 drops same-cycle push and pop
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      step();
      bus.out_ready = 1'b1;
      bus.flush     = 1'b1;
      step();
      bus.flush    = 1'b0;
      bus.in_valid = 1'b0;
      chk("fl1_count", 64'(bus.count), 64'd0);
      step();
      chk("fl1_dropped", 64'(bus.count), 64'd0);

      // Reset mid-operation overrides pending push
      fill2();
      reset        = 1'b0;
      bus.in_valid = 1'b1;
      step();
      reset        = 1'b1;
      bus.in_valid = 1'b0;
      chk("mr_count",    64'(bus.count),     64'd0);
      chk("mr_valid",    64'(bus.out_valid), 64'd0);
      chk("mr_ext",      64'(bus.ext),       64'd0);
      chk("mr_in_ready", 64'(bus.in_ready),  64'd1);
      bus.out_ready = 1'b1;

      // Randomized traffic against a queue model
      exp_q.delete();
      for (int c = 0; c < 600; c++) begin
         logic        push_m;
         logic        pop_m;
         logic [31:0] val;
         bus.in_valid  = ($urandom_range(0, 2) != 0);
         bus.out_ready = ($urandom_range(0, 2) != 0);
         bus.imm       = 16'($urandom);
         bus.EOp       = 2'($urandom);
         bus.flush     = ($urandom_range(0, 24) == 0);
         push_m = bus.in_valid && (exp_q.size() < DEPTH);
         pop_m  = (exp_q.size() != 0) && bus.out_ready;
         val    = model_ext(bus.imm, bus.EOp);
         step();
         if (bus.flush) begin
            exp_q.delete();
         end else begin
            if (pop_m)  void'(exp_q.pop_front());
            if (push_m) exp_q.push_back(val);
         end
         chk("rnd_count",     64'(bus.count),     64'(exp_q.size()));
         chk("rnd_out_valid", 64'(bus.out_valid), 64'(exp_q.size() != 0));
         chk("rnd_in_ready",  64'(bus.in_ready),  64'(exp_q.size() < DEPTH));
         chk("rnd_ext",       64'(bus.ext),       (exp_q.size() != 0) ? 64'(exp_q[0]) : 64'd0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
